// File: rtl/kr580_mem_arbiter.sv
// rtl/kr580_mem_arbiter.sv - three-port fixed-priority arbiter (vid > cpu > dma) for the shared KR580 memory
// Optional dma starvation guard: define ARB_STARVE_GUARD_EN.
module kr580_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic          vid_we,
  input  logic [AW-1:0] vid_addr,
  input  logic [DW-1:0] vid_wdata,
  output logic          vid_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    grant,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
      $error("STARVE_LIMIT must be in 1..255");
    end
  endgenerate

  logic [1:0]    state;
  logic [2:0]    ack;
  logic [2:0]    pick;
  logic          starve_win;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  assign starve_win = dma_req && (starve_cnt >= LIMIT);

  // Counts IDLE cycles in which a pending dma request lost; saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dma_req || (state == ST_IDLE && pick[2])) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_win = 1'b0;
`endif

  always_comb begin
    pick = 3'b000;
    if (starve_win)   pick = 3'b100;
    else if (vid_req) pick = 3'b001;
    else if (cpu_req) pick = 3'b010;
    else if (dma_req) pick = 3'b100;
  end

  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    unique case (pick)
      3'b001: begin
        pick_we    = vid_we;
        pick_addr  = vid_addr;
        pick_wdata = vid_wdata;
      end
      3'b010: begin
        pick_we    = cpu_we;
        pick_addr  = cpu_addr;
        pick_wdata = cpu_wdata;
      end
      3'b100: begin
        pick_we    = dma_we;
        pick_addr  = dma_addr;
        pick_wdata = dma_wdata;
      end
      default: begin
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= 3'b000;
      ack       <= 3'b000;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            state     <= ST_ISSUE;
            grant     <= pick;
            mem_addr  <= pick_addr;
            mem_we    <= pick_we;
            mem_wdata <= pick_wdata;
          end
        end
        ST_ISSUE: begin
          // Memory has sampled mem_* at this edge; the write strobe lasts one cycle.
          state  <= ST_RESP;
          mem_we <= 1'b0;
          ack    <= grant;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          grant <= 3'b000;
          ack   <= 3'b000;
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= 3'b000;
          ack    <= 3'b000;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign vid_ack = ack[0];
  assign cpu_ack = ack[1];
  assign dma_ack = ack[2];
  assign rdata   = mem_rdata;
  assign busy    = (state == ST_ISSUE) || (state == ST_RESP);

endmodule

// File: tb/tb_kr580_mem_arbiter.sv
// tb/tb_kr580_mem_arbiter.sv - directed self-checking bench for kr580_mem_arbiter
// Stimulus and sampling on the falling edge; the memory model responds on the rising edge.
module tb_kr580_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vid_req, vid_we, vid_ack;
  logic [15:0] vid_addr;
  logic [7:0]  vid_wdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  grant;
  logic        busy;

  logic [7:0]  mem [0:65535];
  int          we_cnt;
  int          n_checks;
  int          n_pass;

  kr580_mem_arbiter #(.AW(16), .DW(8), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_wdata(vid_wdata), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wd);
    case (port)
      0: begin vid_req = req; vid_we = we; vid_addr = addr; vid_wdata = wd; end
      1: begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
      default: begin dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; end
    endcase
  endtask

  // Requests are raised on a falling edge in IDLE; lat counts falling edges until the ack.
  task automatic access(input int port, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd, output int lat,
                        output logic [2:0] g);
    logic [2:0] acks;
    rd  = 8'h00;
    g   = 3'b000;
    lat = -1;
    set_req(port, 1'b1, we, addr, wd);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      acks = {dma_ack, cpu_ack, vid_ack};
      if (acks[port]) begin
        lat = c;
        rd  = rdata;
        g   = grant;
      end
    end
    set_req(port, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(2, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++;
    if ({dma_ack, cpu_ack, vid_ack} !== 3'b000)
      $display("FAIL reset_acks: got %b want 000", {dma_ack, cpu_ack, vid_ack});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00)
      $display("FAIL reset_mem_bus: got addr %h data %h want 0000 00", mem_addr, mem_wdata);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_cpu_write_read();
    logic [7:0] rd;
    logic [2:0] g;
    int         lat;
    int         w0;
    w0 = we_cnt;
    access(1, 1'b1, 16'h1234, 8'hA5, rd, lat, g);
    n_checks++; if (lat !== 2) $display("FAIL cpu_write_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (g !== 3'b010) $display("FAIL cpu_write_grant: got %b want 010", g); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_cnt - w0 !== 1) $display("FAIL cpu_write_we_pulses: got %0d want 1", we_cnt - w0); else n_pass++;
    access(1, 1'b0, 16'h1234, 8'h00, rd, lat, g);
    n_checks++; if (lat !== 2) $display("FAIL cpu_read_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 8'hA5) $display("FAIL cpu_read_data: got %h want a5", rd); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_cnt - w0 !== 1) $display("FAIL cpu_read_no_write: got %0d want 1", we_cnt - w0); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int first[3];
    int bad_grant;
    int multi_ack;
    logic [2:0] acks;
    first = '{-1, -1, -1};
    bad_grant = 0;
    multi_ack = 0;
    set_req(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h1234, 8'h00);
    set_req(2, 1'b1, 1'b0, 16'h0200, 8'h00);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      acks = {dma_ack, cpu_ack, vid_ack};
      if (grant !== 3'b000 && !$onehot(grant)) bad_grant++;
      if (acks !== 3'b000 && !$onehot(acks)) multi_ack++;
      for (int p = 0; p < 3; p++) begin
        if (acks[p] && first[p] < 0) begin
          first[p] = c;
          set_req(p, 1'b0, 1'b0, 16'h0, 8'h0);
        end
      end
    end
    n_checks++; if (first[0] !== 2) $display("FAIL simul_vid_ack: got %0d want 2", first[0]); else n_pass++;
    n_checks++; if (first[1] !== 5) $display("FAIL simul_cpu_ack: got %0d want 5", first[1]); else n_pass++;
    n_checks++; if (first[2] !== 8) $display("FAIL simul_dma_ack: got %0d want 8", first[2]); else n_pass++;
    n_checks++; if (bad_grant !== 0) $display("FAIL simul_grant_onehot: got %0d bad cycles want 0", bad_grant); else n_pass++;
    n_checks++; if (multi_ack !== 0) $display("FAIL simul_single_ack: got %0d bad cycles want 0", multi_ack); else n_pass++;
  endtask

  task automatic test_starvation();
    int vid_n, cpu_n, dma_n, dma_first;
    vid_n = 0; cpu_n = 0; dma_n = 0; dma_first = -1;
    set_req(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h1234, 8'h00);
    set_req(2, 1'b1, 1'b0, 16'h0200, 8'h00);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (vid_ack) vid_n++;
      if (cpu_ack) cpu_n++;
      if (dma_ack) begin
        dma_n++;
        if (dma_first < 0) dma_first = c;
      end
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(2, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
    n_checks++;
    if (dma_first < 1 || dma_first > 33)
      $display("FAIL starve_guard_dma_ack: got first ack at %0d want 1..33", dma_first);
    else n_pass++;
`else
    n_checks++; if (dma_n !== 0) $display("FAIL starve_dma_acks: got %0d want 0", dma_n); else n_pass++;
    n_checks++; if (vid_n !== 33) $display("FAIL starve_vid_acks: got %0d want 33", vid_n); else n_pass++;
    n_checks++; if (cpu_n !== 0) $display("FAIL starve_cpu_acks: got %0d want 0", cpu_n); else n_pass++;
`endif
    n_checks++; if (busy !== 1'b0) $display("FAIL starve_idle_after: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd;
    logic [2:0] g;
    int         lat;
    int         bad_ack;
    bad_ack = 0;
    set_req(2, 1'b1, 1'b1, 16'h0010, 8'h99);
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || grant !== 3'b100)
      $display("FAIL abort_issue_state: got we %b grant %b want 1 100", mem_we, grant);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL abort_we_drop: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL abort_idle: got grant %b busy %b want 000 0", grant, busy); else n_pass++;
    set_req(2, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dma_ack !== 1'b0) bad_ack++;
      if (c == 1) rst_n = 1'b1;
    end
    n_checks++; if (bad_ack !== 0) $display("FAIL abort_no_ack: got %0d acks want 0", bad_ack); else n_pass++;
    access(1, 1'b0, 16'h0010, 8'h00, rd, lat, g);
    n_checks++; if (rd !== 8'h3C || lat !== 2) $display("FAIL abort_old_data: got %h lat %0d want 3c lat 2", rd, lat); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ack_cyc[$];
    set_req(0, 1'b1, 1'b0, 16'h0040, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (vid_ack) ack_cyc.push_back(c);
    end
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack_cyc.size() != 2)
      $display("FAIL b2b_ack_count: got %0d want 2", ack_cyc.size());
    else n_pass++;
    n_checks++;
    if (ack_cyc.size() == 2 && (ack_cyc[0] != 2 || ack_cyc[1] != 5))
      $display("FAIL b2b_ack_cycles: got %0d,%0d want 2,5", ack_cyc[0], ack_cyc[1]);
    else if (ack_cyc.size() != 2)
      $display("FAIL b2b_ack_cycles: got %0d acks want acks at 2,5", ack_cyc.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    we_cnt   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h3C;
    test_reset();
    test_cpu_write_read();
    test_simultaneous();
    test_starvation();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
